sensor_emul353: RTL and testbench
=================================

Name: sensor_emul353

Overview:
Sensor-side transmitter that emulates a parallel CMOS sensor, driving the same VACT/HACT/PXD[11:0] interface the pad/phase receiver consumes. It produces complete frames: VACT pulse, vertical blank, then lines of HACT-qualified pixel data with horizontal blank, using programmable geometry and a test pattern. It is used for loopback bring-up of the sensor input path and for simulation benches without a real sensor board.

Parameters:
VACT_LEN, 4, VACT pulse width in clk cycles (min 1)
DW, 12, pixel data width
FCNT_W, 16, frame counter width

Ports:
clk  input  1  pixel clock, all logic on posedge
rst  input  1  reset, asynchronous, active-high
en  input  1  1 = emulator enabled; 0 = finish current frame, then idle
trig_mode  input  1  1 = one frame per trig; 0 = free-running
trig  input  1  frame start request, single-cycle, sampled only in IDLE
hact_len  input  14  active pixels per line minus 1
lines  input  14  active lines per frame minus 1
hblank  input  10  horizontal blank minus 1 (HACT low cycles between lines)
vblank  input  16  cycles between VACT fall and first HACT (0 allowed)
pat_mode  input  2  0 ramp-x, 1 x+y, 2 constant, 3 {frame[3:0],x[7:0]}
pat_const  input  12  value for pat_mode 2
vact  output  1  frame sync to receiver
hact  output  1  line valid to receiver
pxd  output  12  pixel data, valid while hact=1, 0 otherwise
busy  output  1  1 from VSYNC entry until return to IDLE
trig_missed  output  1  single-cycle pulse: trig arrived while not IDLE
frame_cnt  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (async): state IDLE; vact=0, hact=0, pxd=0, busy=0, trig_missed=0, frame_cnt=0, x=y=0. Reset mid-frame aborts immediately with no partial-line completion.
- All outputs registered; no combinational path from any input to any output.
- States: IDLE, VSYNC, VBLANK, LINE, HBLANK.
- IDLE -> VSYNC when en & (trig_mode ? trig : 1). Start condition true in cycle t: vact=1 in cycles t+1..t+VACT_LEN; busy=1 from t+1.
- Frame-start latch: hact_len, lines, hblank, vblank, pat_mode, pat_const captured on the IDLE->VSYNC transition. Changes mid-frame have no effect until the next frame.
- VSYNC -> VBLANK after VACT_LEN cycles.
- VBLANK lasts vblank cycles (vact=0, hact=0). If vblank=0, the first HACT cycle immediately follows the last VACT cycle.
- LINE: hact=1 for hact_len+1 cycles; x counts 0..hact_len; pxd is the pattern value for (x, y).
- LINE -> HBLANK: hact=0 and pxd=0 for hblank+1 cycles, then LINE with y+1.
- After HBLANK of line y==lines: frame_cnt+1 (wraps). Then:
  - free-run with en=1: go directly to VSYNC; the next VACT starts the cycle after the last hblank cycle, with a fresh config latch.
  - otherwise: go to IDLE; busy=0 in that same cycle.
- en=0 mid-frame: frame completes normally, then IDLE.
- trig while not IDLE: trig_missed pulses for 1 cycle, 1 cycle later; the frame is not queued.
- trig and en fall in the same IDLE cycle: no start.
- Pattern arithmetic is modulo 2^12:
  - ramp-x = x[11:0]
  - x+y = (x+y)[11:0]
  - mode 3 uses the frame_cnt value at frame start.
- Minimum geometry (all fields 0): one 1-pixel line, 1-cycle HBLANK; must work.

Decomposition:
- Shared package sensor_emul_pkg:
  - state encoding constants
  - pat_mode constants PAT_RAMPX, PAT_XY, PAT_CONST, PAT_FRAME
  - geometry field widths (14, 10, 16)
- One sub-module, sensor_emul_pattern: registered pixel generator taking x, y, frame, mode and const, with 1-cycle latency. The top aligns hact by delaying it one stage so that pxd and hact stay coincident.

Test Plan:
- Free-run, hact_len=3, lines=1, hblank=1, vblank=2, pat_mode=0 -> per frame: vact 4 cycles, 2 blank, hact 4 cycles pxd 0,1,2,3, 2 low, hact 4 cycles pxd 0,1,2,3, 2 low, then next vact; frame_cnt increments by 1 per frame.
- trig_mode=1, trig at cycle 10 -> vact=1 in cycles 11..14, busy=1 from 11; second trig mid-frame -> trig_missed pulse, no extra frame; busy=0 after last hblank.
- pat_mode=1, hact_len=2, lines=2 -> pxd rows {0,1,2}, {1,2,3}, {2,3,4}; pat_mode=2 with pat_const=0xABC -> every active pixel is 0xABC, and pxd=0 outside hact.
- Change hact_len from 7 to 3 mid-frame -> current frame keeps 8-pixel lines; next frame uses 4-pixel lines. Deassert en mid-frame -> frame completes, then IDLE.
- All geometry fields 0, free-run -> repeating vact×4, hact×1 (pxd=0), 1 low cycle; frame_cnt preset near 0xFFFF wraps to 0.
- Assert rst during LINE -> vact=hact=pxd=busy=0 in the same cycle (async); after release with trig_mode=1 and no trig, the block stays IDLE.

Source files
------------

// File: rtl/sensor_emul_pkg.sv
// rtl/sensor_emul_pkg.sv - shared constants and types for the parallel sensor emulator
package sensor_emul_pkg;

  localparam int HACT_W   = 14;
  localparam int LINES_W  = 14;
  localparam int HBLANK_W = 10;
  localparam int VBLANK_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBLANK = 3'd2;
  localparam logic [2:0] ST_LINE   = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;

  localparam logic [1:0] PAT_RAMPX = 2'd0;
  localparam logic [1:0] PAT_XY    = 2'd1;
  localparam logic [1:0] PAT_CONST = 2'd2;
  localparam logic [1:0] PAT_FRAME = 2'd3;

  // frame geometry snapshot taken when a frame starts
  typedef struct packed {
    logic [HACT_W-1:0]   hact_len;
    logic [LINES_W-1:0]  lines;
    logic [HBLANK_W-1:0] hblank;
    logic [VBLANK_W-1:0] vblank;
  } geo_t;

endpackage

// File: rtl/sensor_emul_pattern.sv
// rtl/sensor_emul_pattern.sv - registered test-pattern pixel generator, 1-cycle latency
module sensor_emul_pattern
  import sensor_emul_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [11:0]   i_x,
  input  logic [11:0]   i_y,
  input  logic [3:0]    i_frame,
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_const,
  output logic [DW-1:0] o_pxd
);

  logic [11:0]   w_sum;
  logic [DW-1:0] w_val;
  logic [DW-1:0] r_pxd;

  // 12-bit sum so x+y wraps modulo 4096
  assign w_sum = i_x + i_y;

  // pattern value for the pixel that goes on the bus next cycle
  always_comb begin
    w_val = '0;
    case (i_mode)
      PAT_RAMPX: w_val = DW'(i_x);
      PAT_XY:    w_val = DW'(w_sum);
      PAT_CONST: w_val = i_const;
      PAT_FRAME: w_val = DW'({i_frame, i_x[7:0]});
      default:   w_val = '0;
    endcase
  end

  // blank cycles are forced to zero so pxd is clean outside hact
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pxd <= '0;
    end else begin
      r_pxd <= i_valid ? w_val : '0;
    end
  end

  assign o_pxd = r_pxd;

endmodule

// File: rtl/sensor_emul353.sv
// rtl/sensor_emul353.sv - parallel CMOS sensor emulator driving VACT/HACT/PXD frames
module sensor_emul353
  import sensor_emul_pkg::*;
#(
  parameter int VACT_LEN = 4,
  parameter int DW       = 12,
  parameter int FCNT_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_trig_mode,
  input  logic                i_trig,
  input  logic [HACT_W-1:0]   i_hact_len,
  input  logic [LINES_W-1:0]  i_lines,
  input  logic [HBLANK_W-1:0] i_hblank,
  input  logic [VBLANK_W-1:0] i_vblank,
  input  logic [1:0]          i_pat_mode,
  input  logic [DW-1:0]       i_pat_const,
  output logic                o_vact,
  output logic                o_hact,
  output logic [DW-1:0]       o_pxd,
  output logic                o_busy,
  output logic                o_trig_missed,
  output logic [FCNT_W-1:0]   o_frame_cnt
);

  localparam logic [VBLANK_W-1:0] VACT_LAST = VBLANK_W'(VACT_LEN - 1);

  logic [2:0]          r_state;
  logic [VBLANK_W-1:0] r_cnt;
  logic [HACT_W-1:0]   r_x;
  logic [LINES_W-1:0]  r_y;
  geo_t                r_geo;
  logic [1:0]          r_pat_mode;
  logic [DW-1:0]       r_pat_const;
  logic [3:0]          r_frame_lo;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                r_vact;
  logic                r_hact;
  logic                r_busy;
  logic                r_trig_missed;

  logic [2:0]          w_state_nxt;
  logic [VBLANK_W-1:0] w_cnt_nxt;
  logic [HACT_W-1:0]   w_x_nxt;
  logic [LINES_W-1:0]  w_y_nxt;
  logic                w_frame_done;
  logic                w_start;
  logic                w_cfg_load;

  assign w_start    = i_en & (i_trig_mode ? i_trig : 1'b1);
  // a fresh snapshot is taken on every entry into VSYNC, including free-run back-to-back frames
  assign w_cfg_load = (w_state_nxt == ST_VSYNC) && (r_state != ST_VSYNC);

  // frame sequencer: next state and counters for the cycle about to be driven on the bus
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_VSYNC;
          w_cnt_nxt   = '0;
        end
      end
      ST_VSYNC: begin
        if (r_cnt == VACT_LAST) begin
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = (r_geo.vblank == '0) ? ST_LINE : ST_VBLANK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_VBLANK: begin
        if (r_cnt == r_geo.vblank - 1'b1) begin
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = ST_LINE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_LINE: begin
        if (r_x == r_geo.hact_len) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HBLANK;
        end else begin
          w_x_nxt = r_x + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == VBLANK_W'(r_geo.hblank)) begin
          w_cnt_nxt = '0;
          if (r_y == r_geo.lines) begin
            w_frame_done = 1'b1;
            w_state_nxt  = (i_en && !i_trig_mode) ? ST_VSYNC : ST_IDLE;
          end else begin
            w_x_nxt     = '0;
            w_y_nxt     = r_y + 1'b1;
            w_state_nxt = ST_LINE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // sequencer state, frame snapshot and frame counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_geo       <= '0;
      r_pat_mode  <= PAT_RAMPX;
      r_pat_const <= '0;
      r_frame_lo  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      if (w_cfg_load) begin
        r_geo       <= '{i_hact_len, i_lines, i_hblank, i_vblank};
        r_pat_mode  <= i_pat_mode;
        r_pat_const <= i_pat_const;
      end
      // low nibble kept apart so the frame pattern does not depend on FCNT_W
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_frame_lo  <= r_frame_lo + 1'b1;
      end
    end
  end

  // bus strobes registered from the upcoming state, one stage alongside the pattern register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vact        <= 1'b0;
      r_hact        <= 1'b0;
      r_busy        <= 1'b0;
      r_trig_missed <= 1'b0;
    end else begin
      r_vact        <= (w_state_nxt == ST_VSYNC);
      r_hact        <= (w_state_nxt == ST_LINE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_trig_missed <= i_trig && (r_state != ST_IDLE);
    end
  end

  sensor_emul_pattern #(
    .DW (DW)
  ) u_pattern (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_state_nxt == ST_LINE),
    .i_x     (w_x_nxt[11:0]),
    .i_y     (w_y_nxt[11:0]),
    .i_frame (r_frame_lo),
    .i_mode  (r_pat_mode),
    .i_const (r_pat_const),
    .o_pxd   (o_pxd)
  );

  assign o_vact        = r_vact;
  assign o_hact        = r_hact;
  assign o_busy        = r_busy;
  assign o_trig_missed = r_trig_missed;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_sensor_emul353.sv
// tb/tb_sensor_emul353.sv - self-checking bench for sensor_emul353
module tb_sensor_emul353;

  localparam int VACT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, trig_mode, trig;
  logic [13:0] hact_len, lines;
  logic [9:0]  hblank;
  logic [15:0] vblank;
  logic [1:0]  pat_mode;
  logic [11:0] pat_const;

  logic        vact, hact, busy, tmiss;
  logic [11:0] pxd;
  logic [15:0] fcnt;
  logic        vact3, hact3, busy3, tmiss3;
  logic [11:0] pxd3;
  logic [2:0]  fcnt3;

  int checks = 0;
  int errors = 0;
  int fexp   = 0;

  typedef struct packed {
    logic [13:0] hl;
    logic [13:0] ln;
    logic [9:0]  hb;
    logic [15:0] vb;
    logic [1:0]  pm;
    logic [11:0] pc;
  } cfg_t;

  typedef struct packed {
    logic        vact;
    logic        hact;
    logic [11:0] pxd;
    logic        busy;
    logic [15:0] fcnt;
  } obs_t;

  typedef struct packed {
    logic        en, tm, trig;
    logic        vact, hact;
    logic [11:0] pxd;
    logic        busy, miss;
  } vec_t;

  obs_t exp_q[$];
  vec_t tbl[21];

  sensor_emul353 #(.VACT_LEN(VACT), .DW(12), .FCNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig_mode(trig_mode), .i_trig(trig),
    .i_hact_len(hact_len), .i_lines(lines), .i_hblank(hblank), .i_vblank(vblank),
    .i_pat_mode(pat_mode), .i_pat_const(pat_const),
    .o_vact(vact), .o_hact(hact), .o_pxd(pxd), .o_busy(busy),
    .o_trig_missed(tmiss), .o_frame_cnt(fcnt)
  );

  sensor_emul353 #(.VACT_LEN(VACT), .DW(12), .FCNT_W(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig_mode(trig_mode), .i_trig(trig),
    .i_hact_len(hact_len), .i_lines(lines), .i_hblank(hblank), .i_vblank(vblank),
    .i_pat_mode(pat_mode), .i_pat_const(pat_const),
    .o_vact(vact3), .o_hact(hact3), .o_pxd(pxd3), .o_busy(busy3),
    .o_trig_missed(tmiss3), .o_frame_cnt(fcnt3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  function automatic vec_t mkv(input logic e, tm, tr, v, h, input logic [11:0] p,
                               input logic b, m);
    vec_t r;
    r.en = e; r.tm = tm; r.trig = tr; r.vact = v; r.hact = h; r.pxd = p;
    r.busy = b; r.miss = m;
    return r;
  endfunction

  function automatic logic [11:0] pat(input cfg_t c, input int x, input int y, input int f);
    case (c.pm)
      2'd0:    return 12'(x % 4096);
      2'd1:    return 12'((x + y) % 4096);
      2'd2:    return c.pc;
      default: return 12'((f % 16) * 256 + (x % 256));
    endcase
  endfunction

  function automatic int flen(input cfg_t c);
    return VACT + int'(c.vb) + (int'(c.ln) + 1) * (int'(c.hl) + 1 + int'(c.hb) + 1);
  endfunction

  task automatic push(input logic v, h, input logic [11:0] p, input logic b, input int f);
    obs_t o;
    o.vact = v; o.hact = h; o.pxd = p; o.busy = b; o.fcnt = 16'(f);
    exp_q.push_back(o);
  endtask

  // cycle-by-cycle picture of one whole frame, then the completed-frame count advances
  task automatic model_frame(input cfg_t c);
    for (int i = 0; i < VACT; i++) push(1, 0, 12'h0, 1, fexp);
    for (int i = 0; i < int'(c.vb); i++) push(0, 0, 12'h0, 1, fexp);
    for (int y = 0; y <= int'(c.ln); y++) begin
      for (int x = 0; x <= int'(c.hl); x++) push(0, 1, pat(c, x, y, fexp), 1, fexp);
      for (int h = 0; h <= int'(c.hb); h++) push(0, 0, 12'h0, 1, fexp);
    end
    fexp++;
  endtask

  task automatic push_idle();
    push(0, 0, 12'h0, 0, fexp);
    push(0, 0, 12'h0, 0, fexp);
  endtask

  task automatic check_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      obs_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s model ran dry got=0 expected=%0d", tag, n);
        return;
      end
      e = exp_q.pop_front();
      chk(tag, {vact, hact, pxd, busy, fcnt, tmiss}, {e, 1'b0});
      chk({tag, "_w3"}, {vact3, hact3, pxd3, busy3, fcnt3, tmiss3},
          {e.vact, e.hact, e.pxd, e.busy, e.fcnt[2:0], 1'b0});
      step();
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    hact_len = c.hl; lines = c.ln; hblank = c.hb; vblank = c.vb;
    pat_mode = c.pm; pat_const = c.pc;
  endtask

  // free-running frames, en dropped early in the last one so the block returns to IDLE
  task automatic run_free(input cfg_t c, input int n, input string tag);
    apply_cfg(c);
    trig_mode = 1'b0;
    en = 1'b1;
    step();
    for (int k = 0; k < n; k++) model_frame(c);
    push_idle();
    check_n((n - 1) * flen(c) + 1, tag);
    en = 1'b0;
    check_n(exp_q.size(), tag);
  endtask

  task automatic run_trig(input cfg_t c, input string tag);
    apply_cfg(c);
    trig_mode = 1'b1;
    en = 1'b1;
    trig = 1'b1;
    step();
    trig = 1'b0;
    model_frame(c);
    push_idle();
    check_n(exp_q.size(), tag);
  endtask

  initial begin
    cfg_t c, c2;

    rst = 1'b1; en = 1'b0; trig_mode = 1'b0; trig = 1'b0;
    apply_cfg('0);
    step();
    step();
    chk("reset_out", {vact, hact, pxd, busy, tmiss, fcnt}, '0);
    rst = 1'b0;
    step();

    // trig mode on minimum geometry with constant pattern
    c = '0; c.pm = 2'd2; c.pc = 12'hABC;
    apply_cfg(c);
    tbl[0]  = mkv(1, 1, 0, 0, 0, 12'h000, 0, 0);
    tbl[1]  = mkv(1, 1, 1, 0, 0, 12'h000, 0, 0);
    tbl[2]  = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[3]  = mkv(1, 1, 1, 1, 0, 12'h000, 1, 0);
    tbl[4]  = mkv(1, 1, 0, 1, 0, 12'h000, 1, 1);
    tbl[5]  = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[6]  = mkv(1, 1, 0, 0, 1, 12'hABC, 1, 0);
    tbl[7]  = mkv(1, 1, 0, 0, 0, 12'h000, 1, 0);
    tbl[8]  = mkv(0, 1, 1, 0, 0, 12'h000, 0, 0);
    tbl[9]  = mkv(1, 1, 0, 0, 0, 12'h000, 0, 0);
    tbl[10] = mkv(1, 1, 0, 0, 0, 12'h000, 0, 0);
    tbl[11] = mkv(1, 1, 1, 0, 0, 12'h000, 0, 0);
    tbl[12] = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[13] = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[14] = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[15] = mkv(1, 1, 0, 1, 0, 12'h000, 1, 0);
    tbl[16] = mkv(1, 1, 0, 0, 1, 12'hABC, 1, 0);
    tbl[17] = mkv(1, 1, 1, 0, 0, 12'h000, 1, 0);
    tbl[18] = mkv(1, 1, 0, 0, 0, 12'h000, 0, 1);
    tbl[19] = mkv(1, 1, 0, 0, 0, 12'h000, 0, 0);
    tbl[20] = mkv(1, 1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; trig_mode = tbl[i].tm; trig = tbl[i].trig;
      chk($sformatf("tbl_row%0d", i), {vact, hact, pxd, busy, tmiss},
          {tbl[i].vact, tbl[i].hact, tbl[i].pxd, tbl[i].busy, tbl[i].miss});
      step();
    end
    trig = 1'b0;
    en = 1'b0;
    fexp = 2;
    chk("tbl_fcnt", {48'h0, fcnt}, 64'd2);

    // free-run ramp-x, three frames
    c = '0; c.hl = 14'd3; c.ln = 14'd1; c.hb = 10'd1; c.vb = 16'd2; c.pm = 2'd0;
    run_free(c, 3, "free_rampx");

    // x+y rows
    c = '0; c.hl = 14'd2; c.ln = 14'd2; c.pm = 2'd1;
    run_free(c, 1, "pat_xy");

    // geometry changed mid-frame only takes effect on the next frame
    c = '0; c.hl = 14'd7; c.ln = 14'd1; c.hb = 10'd2; c.vb = 16'd3; c.pm = 2'd0;
    c2 = c; c2.hl = 14'd3;
    apply_cfg(c);
    trig_mode = 1'b0;
    en = 1'b1;
    step();
    model_frame(c);
    model_frame(c2);
    push_idle();
    check_n(5, "cfg_change");
    hact_len = 14'd3;
    check_n(flen(c) - 4, "cfg_change");
    en = 1'b0;
    check_n(exp_q.size(), "cfg_change");

    // minimum geometry back-to-back; the 3-bit counter instance wraps along the way
    c = '0;
    run_free(c, 10, "min_geo");

    // randomized geometry and patterns
    for (int r = 0; r < 10; r++) begin
      c.hl = 14'($urandom_range(0, 12));
      c.ln = 14'($urandom_range(0, 3));
      c.hb = 10'($urandom_range(0, 4));
      c.vb = 16'($urandom_range(0, 6));
      c.pm = 2'($urandom_range(0, 3));
      c.pc = 12'($urandom);
      if (r % 2 == 1) run_free(c, 2, $sformatf("rand_free%0d", r));
      else run_trig(c, $sformatf("rand_trig%0d", r));
    end

    // asynchronous reset in the middle of a line
    c = '0; c.hl = 14'd5; c.ln = 14'd2; c.hb = 10'd1; c.vb = 16'd1; c.pm = 2'd1;
    apply_cfg(c);
    trig_mode = 1'b0;
    en = 1'b1;
    step();
    model_frame(c);
    check_n(VACT + 1 + 3, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", {vact, hact, pxd, busy, tmiss, fcnt}, '0);
    exp_q.delete();
    trig_mode = 1'b1;
    en = 1'b1;
    trig = 1'b0;
    step();
    step();
    rst = 1'b0;
    fexp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("post_reset_idle%0d", i), {vact, hact, pxd, busy, tmiss, fcnt}, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
